// File: rtl/dma_breq_arbiter.sv
// Two-master DMA/BREQ arbiter for a 6809 bus: round-robin pick, bounded cycle-steal grants.
// Optional build macro ARB_TIMEOUT_EN abandons a request the CPU never acknowledges.
module dma_breq_arbiter #(
  parameter int unsigned MAX_CYCLES = 14,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       ECLK,
  input  logic       RESET_B,
  input  logic [1:0] REQ_B,
  input  logic       BA,
  input  logic       BS,
  output logic       BREQ_B,
  output logic [1:0] GNT_B,
  output logic       DMA_BUSY,
  output logic       TIMEOUT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GRANT,
    S_RELEASE
  } state_e;

  state_e     state_q, state_d;
  logic       winner_q, winner_d;
  logic       ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ba_low_q, ba_low_d;
  logic       breq_b_q, breq_b_d;
  logic [1:0] gnt_b_q, gnt_b_d;
  logic       busy_q, busy_d;
`ifdef ARB_TIMEOUT_EN
  logic [4:0] tmr_q, tmr_d;
  logic       timeout_q, timeout_d;
`endif

  always_comb begin
    // NOTE: every next-state signal gets a hold value first so no path infers a latch.
    state_d  = state_q;
    winner_d = winner_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ba_low_d = ba_low_q;
    breq_b_d = breq_b_q;
    gnt_b_d  = gnt_b_q;
`ifdef ARB_TIMEOUT_EN
    tmr_d     = tmr_q;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (REQ_B != 2'b11) begin
          // A lone requester wins outright; a tie goes to the round-robin pointer.
          winner_d = (REQ_B == 2'b00) ? ptr_q : REQ_B[0];
          breq_b_d = 1'b0;
          state_d  = S_REQ;
`ifdef ARB_TIMEOUT_EN
          tmr_d = '0;
`endif
        end
      end

      S_REQ: begin
        if (REQ_B[winner_q]) begin
          breq_b_d = 1'b1;
          state_d  = S_RELEASE;
        end else if (BA && BS) begin
          gnt_b_d = winner_q ? 2'b01 : 2'b10;
          cnt_d   = 4'd1;
          state_d = S_GRANT;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmr_q == 5'd31) begin
          breq_b_d  = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_RELEASE;
        end else begin
          tmr_d = tmr_q + 5'd1;
        end
`endif
      end

      S_GRANT: begin
        if (REQ_B[winner_q] || (cnt_q == 4'(MAX_CYCLES))) begin
          gnt_b_d  = 2'b11;
          breq_b_d = 1'b1;
          ptr_d    = ~winner_q;
          state_d  = S_RELEASE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_RELEASE: begin
        // The CPU must drop BA before the gap starts counting.
        if (!ba_low_q) begin
          if (!BA) begin
            if (GAP_CYCLES == 0) begin
              state_d = S_IDLE;
            end else begin
              ba_low_d = 1'b1;
              cnt_d    = 4'd1;
            end
          end
        end else if (cnt_q == 4'(GAP_CYCLES)) begin
          ba_low_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge ECLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q  <= S_IDLE;
      winner_q <= 1'b0;
      ptr_q    <= 1'b0;
      cnt_q    <= '0;
      ba_low_q <= 1'b0;
      breq_b_q <= 1'b1;
      gnt_b_q  <= 2'b11;
      busy_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmr_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q  <= state_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      ba_low_q <= ba_low_d;
      breq_b_q <= breq_b_d;
      gnt_b_q  <= gnt_b_d;
      busy_q   <= busy_d;
`ifdef ARB_TIMEOUT_EN
      tmr_q     <= tmr_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign BREQ_B   = breq_b_q;
  assign GNT_B    = gnt_b_q;
  assign DMA_BUSY = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign TIMEOUT = timeout_q;
`else
  assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_dma_breq_arbiter.sv
// Directed bench for dma_breq_arbiter: a transaction-level model checked every cycle,
// plus hand-computed expectations at the interesting points of each scenario.
module tb_dma_breq_arbiter;

  localparam int MAX = 14;
  localparam int GAP = 1;

  logic       ECLK = 1'b0;
  logic       RESET_B;
  logic [1:0] REQ_B;
  logic       BA;
  logic       BS;
  logic       BREQ_B;
  logic [1:0] GNT_B;
  logic       DMA_BUSY;
  logic       TIMEOUT;

  int n_checks = 0;
  int n_fail   = 0;

  dma_breq_arbiter #(
    .MAX_CYCLES(MAX),
    .GAP_CYCLES(GAP)
  ) dut (
    .ECLK    (ECLK),
    .RESET_B (RESET_B),
    .REQ_B   (REQ_B),
    .BA      (BA),
    .BS      (BS),
    .BREQ_B  (BREQ_B),
    .GNT_B   (GNT_B),
    .DMA_BUSY(DMA_BUSY),
    .TIMEOUT (TIMEOUT)
  );

  always #5 ECLK = ~ECLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Bus-ownership view of the arbiter: who is asking, who owns the bus, how long, cool-down.
  typedef struct {
    bit asking;
    bit cooling;
    int owner;
    int cand;
    int held;
    int cool_left;
    int next_pick;
    int waited;
    bit tflag;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.asking    = 1'b0;
    m.cooling   = 1'b0;
    m.owner     = -1;
    m.cand      = 0;
    m.held      = 0;
    m.cool_left = -1;
    m.next_pick = 0;
    m.waited    = 0;
    m.tflag     = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t c, input logic [1:0] r, input logic ba,
                                    input logic bs);
    mdl_t n = c;
    if (n.cooling) begin
      if (n.cool_left < 0) begin
        if (!ba) n.cool_left = GAP;
      end else begin
        n.cool_left--;
      end
      if (n.cool_left == 0) begin
        n.cooling   = 1'b0;
        n.cool_left = -1;
      end
    end else if (n.owner >= 0) begin
      if (r[n.owner] || n.held == MAX) begin
        n.next_pick = 1 - n.owner;
        n.owner     = -1;
        n.asking    = 1'b0;
        n.cooling   = 1'b1;
      end else begin
        n.held++;
      end
    end else if (n.asking) begin
      if (r[n.cand]) begin
        n.asking  = 1'b0;
        n.cooling = 1'b1;
      end else if (ba && bs) begin
        n.owner = n.cand;
        n.held  = 1;
      end else begin
        n.waited++;
`ifdef ARB_TIMEOUT_EN
        if (n.waited == 32) begin
          n.asking  = 1'b0;
          n.cooling = 1'b1;
          n.tflag   = 1'b1;
        end
`endif
      end
    end else if (r != 2'b11) begin
      n.cand   = (r == 2'b00) ? n.next_pick : ((r[0] == 1'b0) ? 0 : 1);
      n.asking = 1'b1;
      n.waited = 0;
    end
    return n;
  endfunction

  mdl_t m = mdl_reset();

  always @(posedge ECLK or negedge RESET_B) begin
    if (!RESET_B) m <= mdl_reset();
    else          m <= mdl_next(m, REQ_B, BA, BS);
  end

  always @(negedge ECLK) begin
    if (RESET_B === 1'b1) begin
      check("model_breq", 32'(BREQ_B), 32'(!m.asking));
      check("model_gnt", 32'(GNT_B), (m.owner < 0) ? 32'h3 : ((m.owner == 0) ? 32'h2 : 32'h1));
      check("model_busy", 32'(DMA_BUSY), 32'(m.asking || m.cooling));
      check("model_timeout", 32'(TIMEOUT), 32'(m.tflag));
      check("inv_one_grant", 32'(GNT_B == 2'b00), 32'h0);
      check("inv_grant_needs_breq", 32'((GNT_B != 2'b11) && BREQ_B), 32'h0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge ECLK);
  endtask

  task automatic drive(input logic [1:0] r, input logic ba, input logic bs);
    REQ_B = r;
    BA    = ba;
    BS    = bs;
  endtask

  task automatic restart(input logic [1:0] r, input logic ba, input logic bs);
    RESET_B = 1'b0;
    step(1);
    drive(r, ba, bs);
    RESET_B = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive(2'b11, 1'b0, 1'b0);
    RESET_B = 1'b1;
    #1 RESET_B = 1'b0;
    step(2);
    check("rst_breq", 32'(BREQ_B), 32'h1);
    check("rst_gnt", 32'(GNT_B), 32'h3);
    check("rst_busy", 32'(DMA_BUSY), 32'h0);
    check("rst_timeout", 32'(TIMEOUT), 32'h0);

    // Single master 0; BA without BS is not an acknowledge.
    drive(2'b10, 1'b0, 1'b0);
    RESET_B = 1'b1;
    step(1);
    check("sm_breq_first_edge", 32'(BREQ_B), 32'h0);
    check("sm_busy", 32'(DMA_BUSY), 32'h1);
    drive(2'b10, 1'b1, 1'b0);
    step(1);
    check("sm_no_grant_bs_low", 32'(GNT_B), 32'h3);
    drive(2'b10, 1'b1, 1'b1);
    step(1);
    check("sm_grant_m0", 32'(GNT_B), 32'h2);
    step(3);
    check("sm_grant_held", 32'(GNT_B), 32'h2);
    drive(2'b11, 1'b1, 1'b1);
    step(1);
    check("sm_release_gnt", 32'(GNT_B), 32'h3);
    check("sm_release_breq", 32'(BREQ_B), 32'h1);
    drive(2'b11, 1'b0, 1'b0);
    step(1);
    check("sm_gap_busy", 32'(DMA_BUSY), 32'h1);
    step(1);
    check("sm_idle", 32'(DMA_BUSY), 32'h0);

    // Simultaneous requests after reset: master 0 first, then master 1.
    restart(2'b00, 1'b0, 1'b0);
    step(1);
    check("sim_breq", 32'(BREQ_B), 32'h0);
    drive(2'b00, 1'b1, 1'b1);
    step(1);
    check("sim_first_m0", 32'(GNT_B), 32'h2);
    drive(2'b01, 1'b1, 1'b1);
    step(1);
    check("sim_m0_released", 32'(GNT_B), 32'h3);
    drive(2'b01, 1'b0, 1'b0);
    step(1);
    check("sim_wait_breq", 32'(BREQ_B), 32'h1);
    step(1);
    check("sim_idle", 32'(DMA_BUSY), 32'h0);
    step(1);
    check("sim_m1_breq", 32'(BREQ_B), 32'h0);
    drive(2'b01, 1'b1, 1'b1);
    step(1);
    check("sim_second_m1", 32'(GNT_B), 32'h1);
    drive(2'b00, 1'b1, 1'b1);
    step(2);
    check("no_direct_transfer", 32'(GNT_B), 32'h1);
    drive(2'b10, 1'b1, 1'b1);
    step(1);
    check("m1_released", 32'(GNT_B), 32'h3);
    drive(2'b00, 1'b0, 1'b0);
    step(3);
    check("ptr_back_breq", 32'(BREQ_B), 32'h0);
    drive(2'b00, 1'b1, 1'b1);
    step(1);
    check("ptr_picks_m0", 32'(GNT_B), 32'h2);

    // Grant limit with master 0 holding its request.
    for (int i = 1; i < MAX; i++) begin
      step(1);
      check("limit_held", 32'(GNT_B), 32'h2);
    end
    step(1);
    check("limit_gnt_off", 32'(GNT_B), 32'h3);
    check("limit_breq_off", 32'(BREQ_B), 32'h1);
    step(2);
    check("limit_wait_ba", 32'(BREQ_B), 32'h1);
    drive(2'b00, 1'b0, 1'b0);
    step(1);
    check("limit_ba_low", 32'(BREQ_B), 32'h1);
    step(1);
    check("limit_gap", 32'(BREQ_B), 32'h1);
    step(1);
    check("limit_rerequest", 32'(BREQ_B), 32'h0);
    drive(2'b00, 1'b1, 1'b1);
    step(1);
    check("limit_then_m1", 32'(GNT_B), 32'h1);

    // Reset in the middle of a grant acts without a clock edge.
    step(2);
    #2 RESET_B = 1'b0;
    #1;
    check("rst_mid_gnt", 32'(GNT_B), 32'h3);
    check("rst_mid_breq", 32'(BREQ_B), 32'h1);
    check("rst_mid_busy", 32'(DMA_BUSY), 32'h0);
    step(1);
    check("rst_mid_hold", 32'(GNT_B), 32'h3);

    // Request withdrawn before acknowledge.
    drive(2'b10, 1'b0, 1'b0);
    RESET_B = 1'b1;
    step(1);
    check("wd_breq", 32'(BREQ_B), 32'h0);
    step(1);
    drive(2'b11, 1'b0, 1'b0);
    step(1);
    check("wd_breq_off", 32'(BREQ_B), 32'h1);
    check("wd_no_gnt", 32'(GNT_B), 32'h3);
    check("wd_busy", 32'(DMA_BUSY), 32'h1);
    step(1);
    check("wd_gap_busy", 32'(DMA_BUSY), 32'h1);
    step(1);
    check("wd_idle", 32'(DMA_BUSY), 32'h0);

    // CPU never acknowledges.
    drive(2'b01, 1'b0, 1'b0);
    step(1);
    check("to_breq", 32'(BREQ_B), 32'h0);
    step(31);
    check("to_before_limit", 32'(TIMEOUT), 32'h0);
    check("to_before_breq", 32'(BREQ_B), 32'h0);
    step(1);
`ifdef ARB_TIMEOUT_EN
    check("to_flag", 32'(TIMEOUT), 32'h1);
    check("to_breq_off", 32'(BREQ_B), 32'h1);
    step(5);
    check("to_sticky", 32'(TIMEOUT), 32'h1);
`else
    check("to_none_flag", 32'(TIMEOUT), 32'h0);
    check("to_none_breq", 32'(BREQ_B), 32'h0);
    step(10);
    check("to_none_still_waiting", 32'(BREQ_B), 32'h0);
`endif
    RESET_B = 1'b0;
    #1;
    check("to_cleared", 32'(TIMEOUT), 32'h0);
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_breq_arbiter.md
DMA_BREQ_ARBITER -- requirements
Module: dma_breq_arbiter

Interface
REQ-001 SHALL have parameter MAX_CYCLES, default 14, which sets the maximum ECLK cycles per grant (range 1..15, 6809 DMA/BREQ cycle-steal limit).
REQ-002 SHALL have parameter GAP_CYCLES, default 1, which sets the minimum ECLK cycles, range 0..3, after BA falls before BREQ_B may reassert.
REQ-003 SHALL have port ECLK, input, 1 bit: 6809 E clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET_B, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port REQ_B, input, 2 bits: active-low bus requests from DMA masters 0 and 1, synchronous to ECLK.
REQ-006 SHALL have port BA, input, 1 bit: CPU bus-available status.
REQ-007 SHALL have port BS, input, 1 bit: CPU bus-status.
REQ-008 SHALL have port BREQ_B, output, 1 bit: active-low request to CPU DMA/BREQ pin.
REQ-009 SHALL have port GNT_B, output, 2 bits: active-low grant per master; at most one bit low.
REQ-010 SHALL have port DMA_BUSY, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have port TIMEOUT, output, 1 bit: sticky bus-acknowledge timeout flag.

Function
REQ-012 SHALL implement states IDLE, REQ, GRANT and RELEASE, with all outputs registered.
REQ-013 In IDLE, when any REQ_B bit is sampled low, SHALL latch the winner, drive BREQ_B=0 on the same edge, and enter REQ.
REQ-014 Winner SHALL be the sole requester, or, when both are low on the same edge, the master indicated by the round-robin pointer.
REQ-015 In REQ, when BA=1 and BS=1 are sampled, SHALL drive GNT_B[winner]=0, load the cycle count with 1, and enter GRANT.
REQ-016 In REQ, if REQ_B[winner] is sampled high before the grant, SHALL drive BREQ_B=1 and enter RELEASE without issuing any grant.
REQ-017 In GRANT, SHALL increment the count each cycle.
REQ-018 In GRANT, if REQ_B[winner] is sampled high, or the count equals MAX_CYCLES, SHALL drive GNT_B=2'b11 and BREQ_B=1 on that edge and enter RELEASE.
REQ-019 On GRANT->RELEASE, SHALL set the pointer to the non-winner; a forced release SHALL NOT clear the master's pending request.
REQ-020 In RELEASE, SHALL wait for BA sampled 0, then GAP_CYCLES further cycles, then enter IDLE.
REQ-021 SHALL never assert both GNT_B bits low, and SHALL never assert GNT_B low while BREQ_B=1.
REQ-022 A grant SHALL never transfer directly between masters; every transfer SHALL pass through RELEASE.
REQ-023 Requests arriving in REQ, GRANT or RELEASE from the non-winner SHALL be held pending and arbitrated in IDLE.

Reset
REQ-024 RESET_B low SHALL force BREQ_B=1, GNT_B=2'b11, DMA_BUSY=0, TIMEOUT=0, state IDLE, pointer=0 and count=0 immediately, asynchronously.
REQ-025 Reset asserted mid-grant SHALL release the bus with no glitch on GNT_B.
REQ-026 After RESET_B deasserts, the first arbitration SHALL occur on the next ECLK rising edge.

Configuration
REQ-027 With ARB_TIMEOUT_EN defined, SHALL abandon REQ after 32 ECLK cycles without BA=1 and BS=1.
REQ-028 With ARB_TIMEOUT_EN defined, abandoning REQ SHALL drive BREQ_B=1, set TIMEOUT=1 until reset, and enter RELEASE.
REQ-029 With ARB_TIMEOUT_EN undefined, SHALL wait in REQ indefinitely, tie TIMEOUT to 0, and include no timeout counter.

Verification
REQ-030 Bench SHALL cover single master: REQ_B=2'b10, BA=BS=1 two cycles later -> GNT_B=2'b10 one edge after acknowledge; release on REQ_B=2'b11.
REQ-031 Bench SHALL cover simultaneous requests after reset: REQ_B=2'b00 -> master 0 granted, then master 1 granted after RELEASE and the GAP, with pointer alternation.
REQ-032 Bench SHALL cover grant limit: MAX_CYCLES=14 with REQ_B held low -> GNT_B high after 14 cycles, BREQ_B=1, and re-request only after BA=0 plus 1 cycle.
REQ-033 Bench SHALL cover reset mid-operation: RESET_B low during GRANT -> GNT_B=2'b11 and BREQ_B=1 without waiting for an ECLK edge.
REQ-034 Bench SHALL cover timeout with ARB_TIMEOUT_EN defined: BA held 0 -> TIMEOUT=1 and BREQ_B=1 at cycle 32, TIMEOUT held until reset.
REQ-035 Bench SHALL cover request withdrawal in REQ: REQ_B high before acknowledge -> no GNT_B pulse, and the state returns to IDLE after BA=0 and the GAP.
